syzygy_adc_lane_align: RTL and testbench

- Downstream of the ADC frame-alignment stage.
- Consumes the two 8-bit data-lane ISERDES words of one ADC channel, plus data_valid and bitslip_count from the frame stage.
- Realigns each lane by bitslip_count and merges the lanes into a 16-bit sample.
- Buffers samples in a small FIFO with a ready/valid output toward the capture logic.

---
 rtl/syzygy_adc_lane_align_if.sv | 10 +
 rtl/syzygy_adc_lane_align.sv | 139 +++++++++++++
 tb/tb_syzygy_adc_lane_align.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/syzygy_adc_lane_align_if.sv
// Sample stream from the lane aligner to the capture logic.
// The master drives valid/data and the slave returns ready.
interface syzygy_adc_lane_align_if;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/syzygy_adc_lane_align.sv
// Realigns the two ISERDES data lanes of one ADC channel by bitslip_count.
// Merges the lanes into 16-bit samples and buffers them in a first-word-fall-through FIFO.
module syzygy_adc_lane_align #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SETTLE_WORDS = 2
) (
    input  logic                        slow_clk,
    input  logic                        reset_n,
    input  logic                        data_valid,
    input  logic [3:0]                  bitslip_count,
    input  logic [7:0]                  lane0_q,
    input  logic [7:0]                  lane1_q,
    input  logic                        clear,
    syzygy_adc_lane_align_if.master     m_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        align_error
);
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_WORDS);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    bs_prev_q;
    logic [7:0]    cur0_q, prev0_q, align0_q;
    logic [7:0]    cur1_q, prev1_q, align1_q;
    logic [2:0]    tag_q;
    logic          ovf_q, ovf_d;
    logic          aerr_q, aerr_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic       illegal, run_exit, push, pop, full, empty, push_ok, ovf_set;
    logic [2:0] k;

    // {prev, cur}[15-sh : 8-sh]; sh = 0 yields prev unchanged
    function automatic logic [7:0] align_word(input logic [7:0] prev,
                                              input logic [7:0] cur,
                                              input logic [2:0] sh);
        logic [15:0] cat;
        logic [3:0]  msb;
        cat = {prev, cur};
        msb = 4'd15 - {1'b0, sh};
        return cat[msb -: 8];
    endfunction

    assign k        = bitslip_count[2:0];
    assign illegal  = data_valid && (bitslip_count > 4'd7);
    assign run_exit = (state_q == RUN) && (state_d != RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!data_valid) begin
            state_d = IDLE;
        end else if (illegal) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
                SETTLE: begin
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - 4'd1;
                end
                RUN: begin
                    if (bitslip_count != bs_prev_q) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A word still in flight when RUN is left is never written, including the one at the FIFO input
    assign push    = tag_q[2] && !run_exit;
    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = !empty && m_if.m_ready;
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    assign level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    assign ovf_d   = ovf_set || (ovf_q && !clear);
    assign aerr_d  = illegal || (aerr_q && !clear);

    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bs_prev_q <= '0;
            cur0_q    <= '0;
            prev0_q   <= '0;
            align0_q  <= '0;
            cur1_q    <= '0;
            prev1_q   <= '0;
            align1_q  <= '0;
            tag_q     <= '0;
            ovf_q     <= 1'b0;
            aerr_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bs_prev_q <= bitslip_count;
            cur0_q    <= lane0_q;
            prev0_q   <= cur0_q;
            align0_q  <= align_word(prev0_q, cur0_q, k);
            cur1_q    <= lane1_q;
            prev1_q   <= cur1_q;
            align1_q  <= align_word(prev1_q, cur1_q, k);
            tag_q     <= run_exit ? '0 : {tag_q[1:0], state_q == RUN};
            ovf_q     <= ovf_d;
            aerr_q    <= aerr_d;
            level_q   <= level_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge slow_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {align1_q, align0_q};
    end

    assign m_if.m_valid = !empty;
    assign m_if.m_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level   = level_q;
    assign overflow     = ovf_q;
    assign align_error  = aerr_q;
endmodule

// File: tb/tb_syzygy_adc_lane_align.sv
// Directed bench for syzygy_adc_lane_align: latency, alignment for every k, bitslip change,
// data_valid drop, backpressure/overflow, illegal count, flag clear and asynchronous reset.
module tb_syzygy_adc_lane_align;
    logic       slow_clk = 1'b0;
    logic       reset_n;
    logic       data_valid;
    logic [3:0] bitslip_count;
    logic [7:0] lane0_q;
    logic [7:0] lane1_q;
    logic       clear;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       align_error;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned w;
    logic [7:0]  r0 [9];
    logic [7:0]  r1 [9];

    always #5 slow_clk = ~slow_clk;

    syzygy_adc_lane_align_if m_if ();

    syzygy_adc_lane_align #(.FIFO_DEPTH(16), .SETTLE_WORDS(2)) dut (
        .slow_clk      (slow_clk),
        .reset_n       (reset_n),
        .data_valid    (data_valid),
        .bitslip_count (bitslip_count),
        .lane0_q       (lane0_q),
        .lane1_q       (lane1_q),
        .clear         (clear),
        .m_if          (m_if),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .align_error   (align_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    // Bit b of the aligned word is bit (8 - k + b) of {prev, cur}
    function automatic logic [7:0] ref_align(input logic [7:0] p, input logic [7:0] c, input int unsigned k);
        logic [15:0] cat;
        logic [7:0]  r;
        cat = {p, c};
        for (int unsigned b = 0; b < 8; b++) r[b] = cat[b + 8 - k];
        return r;
    endfunction

    function automatic logic [15:0] word_e(input int unsigned n);
        return {8'(n) ^ 8'h5A, 8'(n)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; data_valid = 1'b0; bitslip_count = '0;
        lane0_q = '0; lane1_q = '0; clear = 1'b0; m_if.m_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(m_if.m_valid), 32'(0));
        chk("rst_data",  32'(m_if.m_data),  32'(0));
        chk("rst_level", 32'(fifo_level),   32'(0));
        chk("rst_ovf",   32'(overflow),     32'(0));
        chk("rst_aerr",  32'(align_error),  32'(0));
        #10 reset_n = 1'b1;
        tick();

        // k = 0 steady stream, latency E+3 after 2 settle words
        data_valid = 1'b1; lane0_q = 8'hA5; lane1_q = 8'h3C; m_if.m_ready = 1'b1;
        repeat (7) tick();
        chk("a_lat_before", 32'(m_if.m_valid), 32'(0));
        tick();
        chk("a_lat_valid", 32'(m_if.m_valid), 32'(1));
        chk("a_data",      32'(m_if.m_data),  32'h3CA5);
        chk("a_level",     32'(fifo_level),   32'(1));
        repeat (4) tick();
        chk("a_steady_data",  32'(m_if.m_data), 32'h3CA5);
        chk("a_steady_level", 32'(fifo_level),  32'(1));
        chk("a_ovf",          32'(overflow),    32'(0));
        data_valid = 1'b0;
        tick();
        chk("a_drop_level", 32'(fifo_level),   32'(0));
        chk("a_drop_valid", 32'(m_if.m_valid), 32'(0));

        // k = 3 on F0/0F and 81/7E, FIFO retains samples across a data_valid drop
        bitslip_count = 4'd3; m_if.m_ready = 1'b0; data_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            lane0_q = (i % 2 == 0) ? 8'hF0 : 8'h0F;
            lane1_q = (i % 2 == 0) ? 8'h81 : 8'h7E;
            tick();
        end
        chk("b_level", 32'(fifo_level), 32'(4));
        data_valid = 1'b0;
        tick();
        chk("b_hold_level", 32'(fifo_level), 32'(4));
        tick();
        chk("b_retain_level", 32'(fifo_level), 32'(4));
        m_if.m_ready = 1'b1;
        chk("b_s0", 32'(m_if.m_data), 32'h0B80); tick();
        chk("b_s1", 32'(m_if.m_data), 32'hF47F); tick();
        chk("b_s2", 32'(m_if.m_data), 32'h0B80); tick();
        chk("b_s3", 32'(m_if.m_data), 32'hF47F); tick();
        chk("b_empty", 32'(m_if.m_valid), 32'(0));

        // every k on random words
        m_if.m_ready = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            bitslip_count = 4'(k); data_valid = 1'b1;
            for (int i = 0; i < 9; i++) begin
                r0[i] = 8'($urandom); r1[i] = 8'($urandom);
                lane0_q = r0[i]; lane1_q = r1[i];
                tick();
            end
            data_valid = 1'b0;
            tick();
            chk($sformatf("c_level_k%0d", k), 32'(fifo_level), 32'(2));
            m_if.m_ready = 1'b1;
            chk($sformatf("c_head0_k%0d", k), 32'(m_if.m_data),
                32'({ref_align(r1[4], r1[5], k), ref_align(r0[4], r0[5], k)}));
            tick();
            chk($sformatf("c_head1_k%0d", k), 32'(m_if.m_data),
                32'({ref_align(r1[5], r1[6], k), ref_align(r0[5], r0[6], k)}));
            tick();
            chk($sformatf("c_empty_k%0d", k), 32'(m_if.m_valid), 32'(0));
            m_if.m_ready = 1'b0;
        end

        // bitslip 2 -> 5 in RUN: write gap, then k = 5 samples
        lane0_q = 8'hB4; lane1_q = 8'h1E; bitslip_count = 4'd2; data_valid = 1'b1;
        repeat (10) tick();
        chk("d_level_k2", 32'(fifo_level), 32'(3));
        bitslip_count = 4'd5;
        repeat (7) tick();
        chk("d_gap_level", 32'(fifo_level), 32'(3));
        tick();
        chk("d_resume_level", 32'(fifo_level), 32'(4));
        data_valid = 1'b0;
        tick();
        chk("d_hold_level", 32'(fifo_level), 32'(4));
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d_k2_%0d", i), 32'(m_if.m_data), 32'h78D2);
            tick();
        end
        chk("d_k5", 32'(m_if.m_data), 32'hC396);
        tick();
        chk("d_empty", 32'(m_if.m_valid), 32'(0));
        m_if.m_ready = 1'b0;

        // backpressure to full, overflow, full push+pop, clear, in-order drain
        bitslip_count = 4'd0; data_valid = 1'b1; w = 0;
        for (int t = 1; t <= 23; t++) begin
            lane0_q = 8'(w); lane1_q = 8'(w) ^ 8'h5A;
            tick();
            w++;
        end
        chk("e_level_full", 32'(fifo_level), 32'(16));
        chk("e_ovf_before", 32'(overflow),   32'(0));
        lane0_q = 8'(w); lane1_q = 8'(w) ^ 8'h5A;
        tick(); w++;
        chk("e_ovf_set",    32'(overflow),   32'(1));
        chk("e_level_drop", 32'(fifo_level), 32'(16));
        m_if.m_ready = 1'b1;
        lane0_q = 8'(w); lane1_q = 8'(w) ^ 8'h5A;
        tick(); w++;
        chk("e_level_pushpop", 32'(fifo_level), 32'(16));
        m_if.m_ready = 1'b0; data_valid = 1'b0;
        tick();
        chk("e_ovf_sticky", 32'(overflow), 32'(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("e_ovf_clear",   32'(overflow),   32'(0));
        chk("e_level_clear", 32'(fifo_level), 32'(16));
        m_if.m_ready = 1'b1;
        for (int unsigned j = 0; j < 16; j++) begin
            chk($sformatf("e_drain_%0d", j), 32'(m_if.m_data), 32'(word_e((j < 15) ? 5 + j : 21)));
            tick();
        end
        chk("e_empty", 32'(m_if.m_valid), 32'(0));
        m_if.m_ready = 1'b0;

        // illegal bitslip, clear vs set, then asynchronous reset mid-stream
        lane0_q = 8'h11; lane1_q = 8'h22; bitslip_count = 4'd9; data_valid = 1'b1;
        tick();
        chk("f_aerr", 32'(align_error), 32'(1));
        repeat (5) tick();
        chk("f_level", 32'(fifo_level),   32'(0));
        chk("f_valid", 32'(m_if.m_valid), 32'(0));
        clear = 1'b1;
        tick();
        chk("f_set_wins", 32'(align_error), 32'(1));
        bitslip_count = 4'd0;
        tick();
        chk("f_clear", 32'(align_error), 32'(0));
        clear = 1'b0; bitslip_count = 4'd9;
        tick();
        chk("f_aerr_again", 32'(align_error), 32'(1));
        bitslip_count = 4'd0;
        repeat (10) tick();
        chk("f_level_run", 32'(fifo_level),   32'(4));
        chk("f_head",      32'(m_if.m_data),  32'h2211);
        chk("f_aerr_held", 32'(align_error),  32'(1));
        #3 reset_n = 1'b0;
        #1;
        chk("g_rst_valid", 32'(m_if.m_valid), 32'(0));
        chk("g_rst_level", 32'(fifo_level),   32'(0));
        chk("g_rst_aerr",  32'(align_error),  32'(0));
        lane0_q = 8'h33; lane1_q = 8'h44; m_if.m_ready = 1'b1;
        #2 reset_n = 1'b1;
        repeat (7) tick();
        chk("g_lat_before", 32'(m_if.m_valid), 32'(0));
        tick();
        chk("g_lat_valid", 32'(m_if.m_valid), 32'(1));
        chk("g_data",      32'(m_if.m_data),  32'h4433);
        chk("g_ovf",       32'(overflow),     32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
